core_cmd_arbiter: RTL and testbench
===================================

CORE_CMD_ARBITER -- requirements
Module: core_cmd_arbiter

Interface
REQ-001 SHALL have parameter NB_PORTS, default 4: number of requester (PE) ports, >=1.
REQ-002 SHALL have parameter QUEUE_DEPTH, default 2: entries per port queue, >=1.
REQ-003 SHALL have parameter CMD_WIDTH, default 24: opaque command word width.
REQ-004 SHALL have parameter TCDM_ADD_WIDTH, default 12, and EXT_ADD_WIDTH, default 29.
REQ-005 SHALL have PORT_ID_WIDTH = max(1, clog2(NB_PORTS)), derived.
REQ-006 clk_i  in  1  single clock; all flops rising-edge.
REQ-007 rst_ni  in  1  asynchronous active-low reset.
REQ-008 push_req_i  in  NB_PORTS  per-port push request.
REQ-009 push_gnt_o  out  NB_PORTS  per-port queue not full.
REQ-010 push_cmd_i  in  NB_PORTS*CMD_WIDTH  packed command words, port p at slice p.
REQ-011 push_tcdm_add_i  in  NB_PORTS*TCDM_ADD_WIDTH; push_ext_add_i  in  NB_PORTS*EXT_ADD_WIDTH; push_twd_i  in  NB_PORTS  2D flag.
REQ-012 twd_ready_i  in  1  2D descriptor available downstream.
REQ-013 cmd_req_o  out  1; cmd_gnt_i  in  1; cmd_o  out  CMD_WIDTH; tcdm_add_o  out  TCDM_ADD_WIDTH; ext_add_o  out  EXT_ADD_WIDTH; cmd_twd_o  out  1; cmd_port_o  out  PORT_ID_WIDTH.
REQ-014 clk_en_o  out  1  enable for downstream clock gate; busy_o  out  1  any queue non-empty.

Function
REQ-015 Each port SHALL own a FIFO of QUEUE_DEPTH entries {cmd, tcdm_add, ext_add, twd}; push accepted when push_req_i[p] & push_gnt_o[p].
REQ-016 push_gnt_o[p] SHALL equal (count[p] != QUEUE_DEPTH), independent of push_req_i and of same-cycle pop (no full bypass).
REQ-017 A pushed entry SHALL become eligible for issue the cycle after acceptance (1-cycle latency, no pass-through).
REQ-018 Same-cycle push and pop on one port SHALL both occur, count unchanged; pointers wrap modulo QUEUE_DEPTH (non-power-of-two supported).
REQ-019 Port p SHALL be eligible when non-empty and (head twd==0 or twd_ready_i==1).
REQ-020 State machine IDLE/OFFER: in IDLE with any eligible port, select per arbitration policy, register selection, go OFFER next cycle; cmd_req_o SHALL be 1 only in OFFER.
REQ-021 In OFFER, cmd_o/tcdm_add_o/ext_add_o/cmd_twd_o/cmd_port_o SHALL present selected head and stay stable until cmd_gnt_i; twd_ready_i is not re-evaluated.
REQ-022 On cmd_req_o & cmd_gnt_i the selected head SHALL pop; if another eligible port exists (after pop) the FSM SHALL select it and remain in OFFER (back-to-back, one issue per cycle), else return to IDLE.
REQ-023 Round-robin: search starts at port (last_granted+1) mod NB_PORTS; last_granted updates only on grant.
REQ-024 cmd_gnt_i while cmd_req_o==0 SHALL be ignored.
REQ-025 busy_o SHALL be OR of non-empty flags; clk_en_o SHALL be busy_o | (|push_req_i) | cmd_req_o.
REQ-026 Outputs outside OFFER SHALL be driven to 0.

Reset
REQ-027 On rst_ni low, asynchronously: all counts/pointers 0, FSM IDLE, last_granted = NB_PORTS-1 (port 0 first), cmd_req_o 0, push_gnt_o all 1, busy_o 0.
REQ-028 Reset mid-OFFER SHALL discard all queued and offered entries without issuing them.

Configuration
REQ-029 Macro MCHAN_CMD_FIXED_PRIO_EN defined: selection SHALL be fixed priority, lowest eligible port index wins, last_granted unused.
REQ-030 Macro MCHAN_CMD_FIXED_PRIO_EN undefined: round-robin per REQ-023.

Verification
REQ-031 NB_PORTS=4, ports 0..3 each push one non-2D entry in the same cycle -> grants in order 0,1,2,3 on four consecutive cycles with cmd_gnt_i=1; with macro, same order.
REQ-032 Port 2 holds 2 entries, port 0 pushes 1 after first grant of port 2 -> RR order 2,0,2; with macro 2,0,2 also, but if port 0 refills continuously -> 0,0,... starves port 2.
REQ-033 QUEUE_DEPTH=2, port 1 pushes 3 back-to-back with cmd_gnt_i=0 -> push_gnt_o[1] 0 after second push, third held; one grant -> push_gnt_o[1] 1 next cycle.
REQ-034 Port 0 head twd=1, twd_ready_i=0, port 1 non-2D entry -> port 1 issued, port 0 waits; twd_ready_i=1 -> port 0 issued, cmd_twd_o=1.
REQ-035 OFFER on port 3, cmd_gnt_i held 0 for 5 cycles while other ports push -> cmd_port_o=3 and payload stable 5 cycles.
REQ-036 rst_ni pulsed low during OFFER with 3 entries queued -> cmd_req_o 0 immediately, busy_o 0, no entry issued after release.

Source files
------------

// File: rtl/core_cmd_arbiter_if.sv
// ============================================================================
// Module   : core_cmd_arbiter_if
// Brief    : Push-side and issue-side handshake bundle of core_cmd_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface core_cmd_arbiter_if #(
    parameter int NB_PORTS       = 4,
    parameter int CMD_WIDTH      = 24,
    parameter int TCDM_ADD_WIDTH = 12,
    parameter int EXT_ADD_WIDTH  = 29
) ();

    localparam int PORT_ID_WIDTH = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;

    // Requester side, one slice per port
    logic [NB_PORTS-1:0]                push_req_i;
    logic [NB_PORTS-1:0]                push_gnt_o;
    logic [NB_PORTS*CMD_WIDTH-1:0]      push_cmd_i;
    logic [NB_PORTS*TCDM_ADD_WIDTH-1:0] push_tcdm_add_i;
    logic [NB_PORTS*EXT_ADD_WIDTH-1:0]  push_ext_add_i;
    logic [NB_PORTS-1:0]                push_twd_i;

    // Downstream issue side
    logic                               twd_ready_i;
    logic                               cmd_req_o;
    logic                               cmd_gnt_i;
    logic [CMD_WIDTH-1:0]               cmd_o;
    logic [TCDM_ADD_WIDTH-1:0]          tcdm_add_o;
    logic [EXT_ADD_WIDTH-1:0]           ext_add_o;
    logic                               cmd_twd_o;
    logic [PORT_ID_WIDTH-1:0]           cmd_port_o;

    modport master (
        output push_req_i, push_cmd_i, push_tcdm_add_i, push_ext_add_i, push_twd_i,
        output twd_ready_i, cmd_gnt_i,
        input  push_gnt_o, cmd_req_o, cmd_o, tcdm_add_o, ext_add_o, cmd_twd_o, cmd_port_o
    );

    modport slave (
        input  push_req_i, push_cmd_i, push_tcdm_add_i, push_ext_add_i, push_twd_i,
        input  twd_ready_i, cmd_gnt_i,
        output push_gnt_o, cmd_req_o, cmd_o, tcdm_add_o, ext_add_o, cmd_twd_o, cmd_port_o
    );

endinterface

`default_nettype wire

// File: rtl/core_cmd_arbiter.sv
// ============================================================================
// Module   : core_cmd_arbiter
// Brief    : Per-port command FIFOs arbitrated onto one downstream issue port.
//            Round-robin by default; fixed priority (lowest index) when
//            MCHAN_CMD_FIXED_PRIO_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_cmd_arbiter #(
    parameter int NB_PORTS       = 4,
    parameter int QUEUE_DEPTH    = 2,
    parameter int CMD_WIDTH      = 24,
    parameter int TCDM_ADD_WIDTH = 12,
    parameter int EXT_ADD_WIDTH  = 29
) (
    input  wire logic         clk_i,
    input  wire logic         rst_ni,
    core_cmd_arbiter_if.slave bus,
    output logic              clk_en_o,
    output logic              busy_o
);

    localparam int PORT_ID_WIDTH = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;
    localparam int c_PTR_W       = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int c_CNT_W       = $clog2(QUEUE_DEPTH + 1);
    localparam int c_ENTRY_W     = CMD_WIDTH + TCDM_ADD_WIDTH + EXT_ADD_WIDTH + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(QUEUE_DEPTH);
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(QUEUE_DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    logic [NB_PORTS-1:0]                w_nonempty;
    logic [NB_PORTS-1:0]                w_elig;
    logic [NB_PORTS-1:0]                w_pop;
    logic [NB_PORTS-1:0]                w_push;
    logic [NB_PORTS-1:0]                w_push_gnt;
    logic [NB_PORTS-1:0][c_ENTRY_W-1:0] w_head_next;
    logic                               w_grant;
    logic                               w_any;
    logic [PORT_ID_WIDTH-1:0]           w_pick;
    logic [c_ENTRY_W-1:0]               w_pick_entry;

    state_t                             r_state;
    logic                               r_cmd_req;
    logic [PORT_ID_WIDTH-1:0]           r_port;
    logic [c_ENTRY_W-1:0]               r_entry;

    assign w_grant = r_cmd_req & bus.cmd_gnt_i;

    generate
        for (genvar p = 0; p < NB_PORTS; p++) begin : g_port
            logic [c_PTR_W-1:0]   r_rd_ptr;
            logic [c_PTR_W-1:0]   r_wr_ptr;
            logic [c_CNT_W-1:0]   r_count;
            logic [c_ENTRY_W-1:0] r_mem [QUEUE_DEPTH];
            logic [c_ENTRY_W-1:0] w_in;
            logic [c_ENTRY_W-1:0] w_head;
            logic [c_ENTRY_W-1:0] w_second;
            logic [c_PTR_W-1:0]   w_rd_inc;
            logic [c_PTR_W-1:0]   w_wr_inc;
            logic                 w_left;

            assign w_in = {bus.push_twd_i[p],
                           bus.push_ext_add_i[p*EXT_ADD_WIDTH +: EXT_ADD_WIDTH],
                           bus.push_tcdm_add_i[p*TCDM_ADD_WIDTH +: TCDM_ADD_WIDTH],
                           bus.push_cmd_i[p*CMD_WIDTH +: CMD_WIDTH]};

            assign w_rd_inc = (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_PTR_W'(1);
            assign w_wr_inc = (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_PTR_W'(1);

            assign w_push_gnt[p] = (r_count != c_FULL);
            assign w_push[p]     = bus.push_req_i[p] & w_push_gnt[p];
            assign w_pop[p]      = w_grant & (r_port == PORT_ID_WIDTH'(p));
            assign w_nonempty[p] = (r_count != '0);

            // Eligibility is judged on the queue as it will look after this
            // cycle's pop; same-cycle pushes are deliberately not visible.
            assign w_head         = r_mem[r_rd_ptr];
            assign w_second       = r_mem[w_rd_inc];
            assign w_head_next[p] = w_pop[p] ? w_second : w_head;
            assign w_left         = w_pop[p] ? (r_count > c_CNT_W'(1)) : w_nonempty[p];
            assign w_elig[p]      = w_left & (~w_head_next[p][c_ENTRY_W-1] | bus.twd_ready_i);

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_rd_ptr <= '0;
                    r_wr_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push[p]) begin
                        r_wr_ptr <= w_wr_inc;
                    end
                    if (w_pop[p]) begin
                        r_rd_ptr <= w_rd_inc;
                    end
                    if (w_push[p] && !w_pop[p]) begin
                        r_count <= r_count + c_CNT_W'(1);
                    end else if (!w_push[p] && w_pop[p]) begin
                        r_count <= r_count - c_CNT_W'(1);
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (w_push[p]) begin
                    r_mem[r_wr_ptr] <= w_in;
                end
            end
        end
    endgenerate

`ifdef MCHAN_CMD_FIXED_PRIO_EN
    always_comb begin
        w_any        = 1'b0;
        w_pick       = '0;
        w_pick_entry = '0;
        for (int p = NB_PORTS - 1; p >= 0; p--) begin
            if (w_elig[p]) begin
                w_any        = 1'b1;
                w_pick       = PORT_ID_WIDTH'(p);
                w_pick_entry = w_head_next[p];
            end
        end
    end
`else
    logic [PORT_ID_WIDTH-1:0] r_last;
    logic [PORT_ID_WIDTH-1:0] w_base;
    logic                     w_hi_any;
    logic [PORT_ID_WIDTH-1:0] w_hi_pick;
    logic [c_ENTRY_W-1:0]     w_hi_entry;
    logic                     w_lo_any;
    logic [PORT_ID_WIDTH-1:0] w_lo_pick;
    logic [c_ENTRY_W-1:0]     w_lo_entry;

    // A grant this cycle makes the granted port the new "last" immediately.
    assign w_base = w_grant ? r_port : r_last;

    always_comb begin
        w_hi_any   = 1'b0;
        w_hi_pick  = '0;
        w_hi_entry = '0;
        w_lo_any   = 1'b0;
        w_lo_pick  = '0;
        w_lo_entry = '0;
        for (int p = NB_PORTS - 1; p >= 0; p--) begin
            if (w_elig[p]) begin
                if (p > int'(w_base)) begin
                    w_hi_any   = 1'b1;
                    w_hi_pick  = PORT_ID_WIDTH'(p);
                    w_hi_entry = w_head_next[p];
                end else begin
                    w_lo_any   = 1'b1;
                    w_lo_pick  = PORT_ID_WIDTH'(p);
                    w_lo_entry = w_head_next[p];
                end
            end
        end
        w_any        = w_hi_any | w_lo_any;
        w_pick       = w_hi_any ? w_hi_pick  : w_lo_pick;
        w_pick_entry = w_hi_any ? w_hi_entry : w_lo_entry;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last <= PORT_ID_WIDTH'(NB_PORTS - 1);
        end else if (w_grant) begin
            r_last <= r_port;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_cmd_req <= 1'b0;
            r_port    <= '0;
            r_entry   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state   <= ST_OFFER;
                        r_cmd_req <= 1'b1;
                        r_port    <= w_pick;
                        r_entry   <= w_pick_entry;
                    end
                end
                ST_OFFER: begin
                    if (bus.cmd_gnt_i) begin
                        if (w_any) begin
                            r_port  <= w_pick;
                            r_entry <= w_pick_entry;
                        end else begin
                            r_state   <= ST_IDLE;
                            r_cmd_req <= 1'b0;
                            r_port    <= '0;
                            r_entry   <= '0;
                        end
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cmd_req <= 1'b0;
                    r_port    <= '0;
                    r_entry   <= '0;
                end
            endcase
        end
    end

    assign bus.push_gnt_o = w_push_gnt;
    assign bus.cmd_req_o  = r_cmd_req;
    assign bus.cmd_port_o = r_port;
    assign {bus.cmd_twd_o, bus.ext_add_o, bus.tcdm_add_o, bus.cmd_o} = r_entry;

    assign busy_o   = |w_nonempty;
    assign clk_en_o = busy_o | (|bus.push_req_i) | r_cmd_req;

endmodule

`default_nettype wire

// File: tb/tb_core_cmd_arbiter.sv
// ============================================================================
// Module   : tb_core_cmd_arbiter
// Brief    : Directed and randomized checks of core_cmd_arbiter against a
//            queue-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_cmd_arbiter;

    localparam int NB = 4;
    localparam int QD = 2;
    localparam int CW = 24;
    localparam int TW = 12;
    localparam int EW = 29;

    typedef struct packed {
        logic          twd;
        logic [EW-1:0] ext;
        logic [TW-1:0] tcdm;
        logic [CW-1:0] cmd;
    } entry_t;

    logic clk = 1'b0;
    logic rst_n;
    logic clk_en;
    logic busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain arrays of queued entries per port
    entry_t mq [NB][QD];
    int     mcnt [NB];
    bit     m_offer;
    int     m_sel;
    int     m_last;
    int     dut_log [$];

    always #5 clk = ~clk;

    core_cmd_arbiter_if #(
        .NB_PORTS(NB), .CMD_WIDTH(CW), .TCDM_ADD_WIDTH(TW), .EXT_ADD_WIDTH(EW)
    ) bus ();

    core_cmd_arbiter #(
        .NB_PORTS(NB), .QUEUE_DEPTH(QD), .CMD_WIDTH(CW),
        .TCDM_ADD_WIDTH(TW), .EXT_ADD_WIDTH(EW)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .bus      (bus),
        .clk_en_o (clk_en),
        .busy_o   (busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int p = 0; p < NB; p++) mcnt[p] = 0;
        m_offer = 1'b0;
        m_sel   = 0;
        m_last  = NB - 1;
    endfunction

    function automatic bit eligible(input int p);
        return (mcnt[p] > 0) && (!mq[p][0].twd || bus.twd_ready_i);
    endfunction

    function automatic int pick();
`ifdef MCHAN_CMD_FIXED_PRIO_EN
        for (int p = 0; p < NB; p++) if (eligible(p)) return p;
`else
        for (int k = 1; k <= NB; k++) if (eligible((m_last + k) % NB)) return (m_last + k) % NB;
`endif
        return -1;
    endfunction

    task automatic check_outputs();
        entry_t        e;
        logic [NB-1:0] g;
        bit            b;
        e = m_offer ? mq[m_sel][0] : '0;
        b = 1'b0;
        for (int p = 0; p < NB; p++) begin
            g[p] = (mcnt[p] != QD);
            b    = b | (mcnt[p] != 0);
        end
        chk("cmd_req",  bus.cmd_req_o, m_offer);
        chk("cmd_port", bus.cmd_port_o, m_offer ? m_sel : 0);
        chk("payload",  {bus.cmd_twd_o, bus.ext_add_o, bus.tcdm_add_o, bus.cmd_o}, e);
        chk("push_gnt", bus.push_gnt_o, g);
        chk("busy",     busy, b);
        chk("clk_en",   clk_en, b | (|bus.push_req_i) | m_offer);
    endtask

    // Advance one clock: model state is updated from the inputs present
    // just before the edge, then the DUT is compared just after it.
    task automatic cycle();
        bit     acc [NB];
        entry_t in_e [NB];
        int     nxt;
        if (bus.cmd_req_o && bus.cmd_gnt_i) dut_log.push_back(int'(bus.cmd_port_o));
        for (int p = 0; p < NB; p++) begin
            acc[p]       = bus.push_req_i[p] && (mcnt[p] < QD);
            in_e[p].twd  = bus.push_twd_i[p];
            in_e[p].ext  = bus.push_ext_add_i[p*EW +: EW];
            in_e[p].tcdm = bus.push_tcdm_add_i[p*TW +: TW];
            in_e[p].cmd  = bus.push_cmd_i[p*CW +: CW];
        end
        if (m_offer && bus.cmd_gnt_i) begin
            for (int i = 0; i < QD - 1; i++) mq[m_sel][i] = mq[m_sel][i+1];
            mcnt[m_sel]--;
            m_last  = m_sel;
            m_offer = 1'b0;
        end
        if (!m_offer) begin
            nxt     = pick();
            m_offer = (nxt >= 0);
            m_sel   = (nxt >= 0) ? nxt : 0;
        end
        for (int p = 0; p < NB; p++) begin
            if (acc[p]) begin
                mq[p][mcnt[p]] = in_e[p];
                mcnt[p]++;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic set_push(input int p, input logic [CW-1:0] c, input logic [TW-1:0] t,
                            input logic [EW-1:0] x, input logic d);
        bus.push_req_i[p]            = 1'b1;
        bus.push_cmd_i[p*CW +: CW]   = c;
        bus.push_tcdm_add_i[p*TW +: TW] = t;
        bus.push_ext_add_i[p*EW +: EW]  = x;
        bus.push_twd_i[p]            = d;
    endtask

    task automatic set_push_rand(input int p, input logic d);
        set_push(p, CW'($urandom), TW'($urandom), EW'($urandom), d);
    endtask

    initial begin
        rst_n               = 1'b0;
        bus.push_req_i      = '0;
        bus.push_cmd_i      = '0;
        bus.push_tcdm_add_i = '0;
        bus.push_ext_add_i  = '0;
        bus.push_twd_i      = '0;
        bus.twd_ready_i     = 1'b1;
        bus.cmd_gnt_i       = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_req",  bus.cmd_req_o, 0);
        chk("rst_push_gnt", bus.push_gnt_o, 4'hF);
        chk("rst_busy",     busy, 0);
        chk("rst_cmd_port", bus.cmd_port_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        // All four ports push together, downstream always grants
        dut_log.delete();
        bus.cmd_gnt_i = 1'b1;
        for (int p = 0; p < NB; p++) set_push_rand(p, 1'b0);
        cycle();
        bus.push_req_i = '0;
        run(6);
        chk("r031_count", dut_log.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("r031_order", (i < dut_log.size()) ? dut_log[i] : -1, i);

        // Port 2 with two entries, port 0 joins while port 2 is offered
        dut_log.delete();
        bus.cmd_gnt_i = 1'b0;
        set_push_rand(2, 1'b0);
        cycle();
        set_push_rand(2, 1'b0);
        cycle();
        bus.push_req_i = '0;
        cycle();
        set_push_rand(0, 1'b0);
        cycle();
        bus.push_req_i = '0;
        bus.cmd_gnt_i  = 1'b1;
        run(5);
        chk("r032_count", dut_log.size(), 3);
        chk("r032_g0", (dut_log.size() > 0) ? dut_log[0] : -1, 2);
        chk("r032_g1", (dut_log.size() > 1) ? dut_log[1] : -1, 0);
        chk("r032_g2", (dut_log.size() > 2) ? dut_log[2] : -1, 2);

        // Port 1 overfills its queue while downstream stalls
        dut_log.delete();
        bus.cmd_gnt_i = 1'b0;
        set_push_rand(1, 1'b0);
        cycle();
        set_push_rand(1, 1'b0);
        cycle();
        chk("r033_full", bus.push_gnt_o[1], 0);
        set_push_rand(1, 1'b0);
        cycle();
        chk("r033_held", bus.push_gnt_o[1], 0);
        bus.cmd_gnt_i = 1'b1;
        cycle();
        chk("r033_reopen", bus.push_gnt_o[1], 1);
        bus.cmd_gnt_i = 1'b0;
        cycle();
        bus.push_req_i = '0;
        bus.cmd_gnt_i  = 1'b1;
        run(5);
        chk("r033_count", dut_log.size(), 3);

        // 2D head waits for twd_ready while a plain entry bypasses it
        dut_log.delete();
        bus.cmd_gnt_i   = 1'b0;
        bus.twd_ready_i = 1'b0;
        set_push_rand(0, 1'b1);
        set_push_rand(1, 1'b0);
        cycle();
        bus.push_req_i = '0;
        cycle();
        chk("r034_first_port", bus.cmd_port_o, 1);
        bus.cmd_gnt_i = 1'b1;
        cycle();
        chk("r034_blocked", bus.cmd_req_o, 0);
        bus.cmd_gnt_i   = 1'b0;
        bus.twd_ready_i = 1'b1;
        cycle();
        chk("r034_twd_port", bus.cmd_port_o, 0);
        chk("r034_twd_flag", bus.cmd_twd_o, 1);
        bus.cmd_gnt_i = 1'b1;
        cycle();
        chk("r034_count", dut_log.size(), 2);

        // Offer on port 3 stays stable under back-pressure
        bus.cmd_gnt_i = 1'b0;
        set_push(3, 24'hA5C35A, 12'h3C5, 29'h0ACE_1234, 1'b0);
        cycle();
        bus.push_req_i = '0;
        cycle();
        for (int k = 0; k < 5; k++) begin
            for (int p = 0; p < 3; p++) begin
                if ($urandom_range(0, 1) == 1) set_push_rand(p, 1'b0);
                else bus.push_req_i[p] = 1'b0;
            end
            cycle();
            chk("r035_port", bus.cmd_port_o, 3);
            chk("r035_cmd",  bus.cmd_o, 24'hA5C35A);
            chk("r035_tcdm", bus.tcdm_add_o, 12'h3C5);
            chk("r035_ext",  bus.ext_add_o, 29'h0ACE_1234);
        end
        bus.push_req_i = '0;
        bus.cmd_gnt_i  = 1'b1;
        run(12);

        // Asynchronous reset while an offer is pending
        bus.cmd_gnt_i = 1'b0;
        for (int p = 0; p < 3; p++) set_push_rand(p, 1'b0);
        cycle();
        bus.push_req_i = '0;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("r036_req",      bus.cmd_req_o, 0);
        chk("r036_busy",     busy, 0);
        chk("r036_push_gnt", bus.push_gnt_o, 4'hF);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        bus.cmd_gnt_i = 1'b1;
        dut_log.delete();
        run(5);
        chk("r036_no_issue", dut_log.size(), 0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < NB; p++) begin
                if ($urandom_range(0, 1) == 1) set_push_rand(p, ($urandom_range(0, 3) == 0));
                else bus.push_req_i[p] = 1'b0;
            end
            bus.twd_ready_i = ($urandom_range(0, 1) == 1);
            bus.cmd_gnt_i   = ($urandom_range(0, 3) != 0);
            cycle();
        end
        bus.push_req_i  = '0;
        bus.twd_ready_i = 1'b1;
        bus.cmd_gnt_i   = 1'b1;
        run(12);
        chk("drain_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
